prbs_chk: RTL

PRBS_CHK -- requirements
Module: prbs_chk

---
 rtl/prbs_pkg.sv | 46 ++++
 rtl/prbs_chk_sat_cnt.sv | 48 ++++
 rtl/prbs_chk.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared types and pure helpers for the PRBS checker: FSM state encoding,
// the Galois LFSR step function and a population count.
package prbs_pkg;

  // Widest word the helpers handle; callers zero-extend into this width.
  localparam int MAX_WIDTH = 64;
  localparam int POP_WIDTH = $clog2(MAX_WIDTH + 1);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // One Galois LFSR advance of a width-bit state held in the low bits of s.
  // Stage width-1 is always fed from stage 0; every lower stage shifts down
  // and picks up stage 0 wherever the tap mask has a bit set. Bits at and
  // above width come back zero.
  function automatic logic [MAX_WIDTH-1:0] prbs_step(
    input logic [MAX_WIDTH-1:0] s,
    input logic [MAX_WIDTH-1:0] poly,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if (i < width - 1) begin
        n[i] = s[i+1] ^ (poly[i] & s[0]);
      end
    end
    n[width-1] = s[0];
    return n;
  endfunction

  // Number of set bits, used to weigh a word error by its bit errors.
  function automatic logic [POP_WIDTH-1:0] popcount(
    input logic [MAX_WIDTH-1:0] v
  );
    logic [POP_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      c = c + POP_WIDTH'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs_chk_sat_cnt.sv
// Saturating accumulator with synchronous clear. A clear in the same cycle
// as an addition yields the addition applied to zero; any sum that does not
// fit in WIDTH bits clamps to all-ones instead of wrapping.
module sat_cnt #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 add_en_i,
  input  logic [ADD_WIDTH-1:0] add_i,
  output logic [WIDTH-1:0]     cnt_o
);

  // One guard bit above the wider operand catches every overflow.
  localparam int SUM_WIDTH = ((WIDTH > ADD_WIDTH) ? WIDTH : ADD_WIDTH) + 1;

  logic [SUM_WIDTH-1:0] base;
  logic [SUM_WIDTH-1:0] incr;
  logic [SUM_WIDTH-1:0] sum;
  logic [WIDTH-1:0]     cnt_d;

  // Next count: clear selects a zero base, then add and clamp.
  always_comb begin
    // NOTE: every variable written here gets a value on every path first;
    // a path that leaves one unassigned would infer a latch.
    base  = clr_i ? '0 : SUM_WIDTH'(cnt_o);
    incr  = add_en_i ? SUM_WIDTH'(add_i) : '0;
    sum   = base + incr;
    cnt_d = sum[WIDTH-1:0];
    if (|sum[SUM_WIDTH-1:WIDTH]) begin
      cnt_d = '1;
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_d;
    end
  end

endmodule

// File: rtl/prbs_chk.sv
// PRBS checker. In SEARCH the received words seed a reference and successive
// beats are compared against its LFSR successor until LOCK_CNT consecutive
// non-zero matches are seen. In LOCKED the reference free-runs (flywheel) so
// a corrupted word never contaminates the prediction; each mismatching beat
// pulses err_o and feeds the word and bit error counters, and LOSS_CNT
// consecutive mismatches drop back to SEARCH seeded from the offending word.
module prbs_chk
  import prbs_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = 32'h8020_0003,
  parameter int                    CNT_WIDTH  = 32,
  parameter int                    LOCK_CNT   = 4,
  parameter int                    LOSS_CNT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  clr_i,
  output logic                  lock_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt_o
);

  // Run counters are 8 bits since both thresholds are limited to 1..255.
  localparam logic [7:0] LOCK_LIM  = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_LIM  = 8'(LOSS_CNT);
  localparam int         BIT_WIDTH = $clog2(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic                  ref_vld_q, ref_vld_d;
  logic [7:0]            match_q, match_d;
  logic [7:0]            miss_q, miss_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] exp_w;
  logic [BIT_WIDTH-1:0]  bit_errs;
  logic                  count_err;
  logic [7:0]            match_inc;
  logic [7:0]            miss_inc;

  // Predicted word and the bit distance of the received word from it.
  assign exp_w     = DATA_WIDTH'(prbs_step(MAX_WIDTH'(ref_q), MAX_WIDTH'(POLY), DATA_WIDTH));
  assign bit_errs  = BIT_WIDTH'(popcount(MAX_WIDTH'(dat_i ^ exp_w)));
  assign match_inc = match_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  // Next-state decode: only beats move the FSM, reference and run counters.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    count_err = 1'b0;

    if (vld_i) begin
      case (state_q)
        SEARCH: begin
          // Every search beat becomes the new reference; the first one after
          // reset has nothing to compare against and only seeds.
          ref_d     = dat_i;
          ref_vld_d = 1'b1;
          if (ref_vld_q) begin
            // All-zero is the LFSR lock-up word and must never qualify.
            if ((dat_i == exp_w) && (|dat_i)) begin
              if (match_inc == LOCK_LIM) begin
                state_d = LOCKED;
                match_d = '0;
                miss_d  = '0;
              end else begin
                match_d = match_inc;
              end
            end else begin
              match_d = '0;
            end
          end
        end

        LOCKED: begin
          // Flywheel: keep predicting from our own sequence.
          ref_d = exp_w;
          if (dat_i != exp_w) begin
            err_d     = 1'b1;
            count_err = 1'b1;
            if (miss_inc == LOSS_LIM) begin
              state_d   = SEARCH;
              ref_d     = dat_i;
              ref_vld_d = 1'b1;
              miss_d    = '0;
              match_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  // Checker state registers; reset wins over beats and clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
    end
  end

  assign lock_o = (state_q == LOCKED);
  assign err_o  = err_q;

  // Word error counter: one per mismatching locked beat.
  sat_cnt #(
    .WIDTH     (CNT_WIDTH),
    .ADD_WIDTH (1)
  ) u_err_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_i),
    .add_en_i (count_err),
    .add_i    (1'b1),
    .cnt_o    (err_cnt_o)
  );

  // Bit error counter: weighted by the number of differing bits.
  sat_cnt #(
    .WIDTH     (CNT_WIDTH),
    .ADD_WIDTH (BIT_WIDTH)
  ) u_bit_err_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr_i),
    .add_en_i (count_err),
    .add_i    (bit_errs),
    .cnt_o    (bit_err_cnt_o)
  );

endmodule
